// File: rtl/lift_seq_ctrl.sv
// Sequencer for one 1-D 5/3 lifting pass over split even/odd sample RAMs.
// Each element runs five steps: three operand reads, a compute cycle and a write-back.
module lift_seq_ctrl #(
    parameter int W  = 20,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fwd_inv_cfg,
    input  logic [AW-1:0] len_m1,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ev_addr,
    output logic [AW-1:0] od_addr,
    output logic          ev_we,
    output logic          od_we,
    output logic [W-1:0]  ev_din,
    output logic [W-1:0]  od_din,
    input  logic [W-1:0]  ev_dout,
    input  logic [W-1:0]  od_dout,
    output logic [W-1:0]  dp_left,
    output logic [W-1:0]  dp_right,
    output logic [W-1:0]  dp_center,
    output logic          dp_p,
    output logic          dp_even_odd,
    output logic          dp_fwd_inv,
    input  logic [W-1:0]  dp_result
);

    typedef enum logic [2:0] {
        IDLE,
        RL,
        RR,
        RC,
        CALC,
        WR,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic          phase;
    logic          phase_next;
    logic          fwd_q;
    logic [AW-1:0] len_q;
    logic          predict;
    logic [AW-1:0] left_idx;
    logic [AW-1:0] right_idx;

    // Forward runs predict first, inverse runs update first.
    assign predict   = fwd_q ? ~phase : phase;
    assign left_idx  = (idx == '0) ? '0 : idx - AW'(1);
    assign right_idx = (idx == len_q) ? idx : idx + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            phase <= 1'b0;
            fwd_q <= 1'b0;
            len_q <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            phase <= phase_next;
            if (state == IDLE && start) begin
                fwd_q <= fwd_inv_cfg;
                len_q <= len_m1;
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        phase_next = phase;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RL;
                    idx_next   = '0;
                    phase_next = 1'b0;
                end
            end
            RL:   state_next = RR;
            RR:   state_next = RC;
            RC:   state_next = CALC;
            CALC: state_next = WR;
            WR: begin
                if (idx != len_q) begin
                    idx_next   = idx + AW'(1);
                    state_next = RL;
                end else if (!phase) begin
                    phase_next = 1'b1;
                    idx_next   = '0;
                    state_next = RL;
                end else begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from registered state so reset clears them without waiting for a clock.
    always_comb begin
        ev_addr     = '0;
        od_addr     = '0;
        ev_we       = 1'b0;
        od_we       = 1'b0;
        ev_din      = '0;
        od_din      = '0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        dp_p        = (state == CALC) || (state == WR);
        dp_even_odd = 1'b0;
        dp_fwd_inv  = fwd_q;
        case (state)
            RL: begin
                dp_even_odd = predict;
                if (predict) ev_addr = idx;
                else         od_addr = left_idx;
            end
            RR: begin
                dp_even_odd = predict;
                if (predict) ev_addr = right_idx;
                else         od_addr = idx;
            end
            RC: begin
                dp_even_odd = predict;
                if (predict) od_addr = idx;
                else         ev_addr = idx;
            end
            CALC: dp_even_odd = predict;
            WR: begin
                dp_even_odd = predict;
                if (predict) begin
                    od_addr = idx;
                    od_we   = 1'b1;
                    od_din  = dp_result;
                end else begin
                    ev_addr = idx;
                    ev_we   = 1'b1;
                    ev_din  = dp_result;
                end
            end
            default: ;
        endcase
    end

    // RAM data arrives one cycle after its address, so each operand is captured a step late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_left   <= '0;
            dp_right  <= '0;
            dp_center <= '0;
        end else begin
            case (state)
                RR:      dp_left   <= predict ? ev_dout : od_dout;
                RC:      dp_right  <= predict ? ev_dout : od_dout;
                CALC:    dp_center <= predict ? od_dout : ev_dout;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lift_seq_ctrl.sv
// Scoreboard bench for lift_seq_ctrl: a per-cycle model of the expected sequence is
// queued at start and popped each cycle, with RAM models and a simple datapath attached.
module tb_lift_seq_ctrl;

    localparam int W  = 20;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fwd_inv_cfg = 1'b0;
    logic [AW-1:0] len_m1 = '0;
    logic          busy, done, ev_we, od_we, dp_p, dp_even_odd, dp_fwd_inv;
    logic [AW-1:0] ev_addr, od_addr;
    logic [W-1:0]  ev_din, od_din, dp_left, dp_right, dp_center;
    logic [W-1:0]  ev_dout = '0;
    logic [W-1:0]  od_dout = '0;
    logic [W-1:0]  dp_result;

    logic          use_const = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_ev = '0;
    logic [W-1:0]  ld_od = '0;
    logic [W-1:0]  ev_mem [128];
    logic [W-1:0]  od_mem [128];
    logic [W-1:0]  ev_ref [128];
    logic [W-1:0]  od_ref [128];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          ev_we;
        logic          od_we;
        logic          dp_p;
        logic          eo;
        logic          fwd;
        logic [AW-1:0] ev_addr;
        logic [AW-1:0] od_addr;
        logic [W-1:0]  ev_din;
        logic [W-1:0]  od_din;
    } item_t;

    item_t exp_q[$];

    lift_seq_ctrl #(.W(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fwd_inv_cfg(fwd_inv_cfg),
        .len_m1(len_m1), .busy(busy), .done(done),
        .ev_addr(ev_addr), .od_addr(od_addr), .ev_we(ev_we), .od_we(od_we),
        .ev_din(ev_din), .od_din(od_din), .ev_dout(ev_dout), .od_dout(od_dout),
        .dp_left(dp_left), .dp_right(dp_right), .dp_center(dp_center),
        .dp_p(dp_p), .dp_even_odd(dp_even_odd), .dp_fwd_inv(dp_fwd_inv),
        .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lift_fn(input logic [W-1:0] l, input logic [W-1:0] r,
                                             input logic [W-1:0] c);
        if (use_const) return 20'h12345;
        return (l + r + (c << 1)) ^ 20'h5A5A5;
    endfunction

    assign dp_result = lift_fn(dp_left, dp_right, dp_center);

    always @(posedge clk) begin
        if (ld_en) begin
            ev_mem[ld_addr] <= ld_ev;
            od_mem[ld_addr] <= ld_od;
        end else begin
            if (ev_we) ev_mem[ev_addr] <= ev_din;
            if (od_we) od_mem[od_addr] <= od_din;
        end
        ev_dout <= ev_mem[ev_addr];
        od_dout <= od_mem[od_addr];
    end

    function automatic item_t observe();
        item_t o;
        o = '{busy: busy, done: done, ev_we: ev_we, od_we: od_we, dp_p: dp_p,
              eo: dp_even_odd, fwd: dp_fwd_inv, ev_addr: ev_addr, od_addr: od_addr,
              ev_din: ev_din, od_din: od_din};
        return o;
    endfunction

    function automatic logic outputs_zero();
        return ({busy, done, ev_addr, od_addr, ev_we, od_we, ev_din, od_din, dp_left,
                 dp_right, dp_center, dp_p, dp_even_odd, dp_fwd_inv} === '0);
    endfunction

    task automatic load_mems(input int m);
        for (int i = 0; i < m; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_ev   = W'($urandom);
            ld_od   = W'($urandom);
            ev_ref[i] = ld_ev;
            od_ref[i] = ld_od;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_step(input logic fwd, input logic pred, input int st,
                             input int ea, input int oa, input logic [W-1:0] din);
        item_t it;
        it         = '0;
        it.busy    = 1'b1;
        it.fwd     = fwd;
        it.eo      = pred;
        it.dp_p    = (st >= 3);
        it.ev_addr = AW'(ea);
        it.od_addr = AW'(oa);
        if (st == 4) begin
            if (pred) begin it.od_we = 1'b1; it.od_din = din; end
            else      begin it.ev_we = 1'b1; it.ev_din = din; end
        end
        exp_q.push_back(it);
    endtask

    // Builds the whole expected cycle sequence and the final RAM image for one pass.
    task automatic build_pass(input logic fwd, input int m);
        item_t it;
        logic  pred;
        int    lo, hi;
        logic [W-1:0] v;
        exp_q.delete();
        for (int ph = 0; ph < 2; ph++) begin
            pred = fwd ? (ph == 0) : (ph == 1);
            for (int i = 0; i < m; i++) begin
                hi = (i + 1 < m) ? i + 1 : m - 1;
                lo = (i > 0) ? i - 1 : 0;
                if (pred) begin
                    v = lift_fn(ev_ref[i], ev_ref[hi], od_ref[i]);
                    push_step(fwd, pred, 0, i, 0, '0);
                    push_step(fwd, pred, 1, hi, 0, '0);
                    push_step(fwd, pred, 2, 0, i, '0);
                    push_step(fwd, pred, 3, 0, 0, '0);
                    push_step(fwd, pred, 4, 0, i, v);
                    od_ref[i] = v;
                end else begin
                    v = lift_fn(od_ref[lo], od_ref[i], ev_ref[i]);
                    push_step(fwd, pred, 0, 0, lo, '0);
                    push_step(fwd, pred, 1, 0, i, '0);
                    push_step(fwd, pred, 2, i, 0, '0);
                    push_step(fwd, pred, 3, 0, 0, '0);
                    push_step(fwd, pred, 4, i, 0, v);
                    ev_ref[i] = v;
                end
            end
        end
        it = '0; it.busy = 1'b1; it.done = 1'b1; it.fwd = fwd;
        exp_q.push_back(it);
        it = '0; it.fwd = fwd;
        exp_q.push_back(it);
    endtask

    task automatic run_pass(input string name, input logic fwd, input int m,
                            input bit poke, input bit hold);
        item_t e, o;
        int    cyc;
        load_mems(m);
        build_pass(fwd, m);
        start       = 1'b1;
        fwd_inv_cfg = fwd;
        len_m1      = AW'(m - 1);
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, o, e);
            end
            if (exp_q.size() > 0) begin
                if (poke) start = 1'($urandom_range(0, 1));
                @(negedge clk);
                cyc++;
            end else begin
                start = hold;
            end
        end
        for (int i = 0; i < m; i++) begin
            checks++;
            if (ev_mem[i] !== ev_ref[i] || od_mem[i] !== od_ref[i]) begin
                errors++;
                $display("[TB] FAIL %s ram[%0d]: got ev %h od %h expected ev %h od %h",
                         name, i, ev_mem[i], od_mem[i], ev_ref[i], od_ref[i]);
            end
        end
    endtask

    // Pulses reset n cycles into an M-sample forward pass and checks the outputs clear at once.
    task automatic abort_pass(input string name, input int m, input int n, input bit at_wr3);
        load_mems(m);
        start       = 1'b1;
        fwd_inv_cfg = 1'b1;
        len_m1      = AW'(m - 1);
        @(negedge clk);
        start = 1'b0;
        repeat (n) @(negedge clk);
        if (at_wr3) begin
            checks++;
            if (od_we !== 1'b1 || od_addr !== AW'(3)) begin
                errors++;
                $display("[TB] FAIL %s pre-reset write: got we %b addr %0d expected we 1 addr 3",
                         name, od_we, od_addr);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("[TB] FAIL %s outputs under reset: got busy %b ev_we %b od_we %b expected all 0",
                     name, busy, ev_we, od_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s resumed: got busy %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("[TB] FAIL reset_initial: got busy %b done %b expected all 0", busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy %b done %b expected all 0", busy, done);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: got busy %b expected all 0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        run_pass("fwd_m2", 1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_inverse();
        run_pass("inv_m1", 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_passthrough();
        use_const = 1'b1;
        run_pass("passthru", 1'b1, 2, 1'b0, 1'b0);
        use_const = 1'b0;
    endtask

    task automatic test_ignore_start();
        run_pass("start_poke_fwd", 1'b1, 4, 1'b1, 1'b0);
        run_pass("start_poke_inv", 1'b0, 3, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_pass("held_start", 1'b0, 3, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || dp_even_odd !== 1'b0 || od_addr !== '0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart: got busy %b eo %b od_addr %0d expected busy 1 eo 0 od_addr 0",
                     busy, dp_even_odd, od_addr);
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < 3; k++) abort_pass("abort_random", 8, $urandom_range(1, 80), 1'b0);
        abort_pass("abort_wr3", 8, 19, 1'b1);
        run_pass("after_abort", 1'b1, 8, 1'b0, 1'b0);
    endtask

    task automatic test_long();
        run_pass("fwd_m128", 1'b1, 128, 1'b0, 1'b0);
        run_pass("inv_rand", 1'b0, $urandom_range(2, 20), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_passthrough();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_long();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_seq_ctrl.md
LIFT_SEQ_CTRL -- requirements
Module: lift_seq_ctrl

Interface
REQ-001 SHALL provide parameter W, default 20, sample width matching the add/mul lifting datapath.
REQ-002 SHALL provide parameter AW, default 7, even/odd RAM address width.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one 1-D lifting pass; sampled in IDLE only.
- fwd_inv_cfg  in  1  1 = forward 5/3, 0 = inverse; latched at start.
- len_m1  in  AW  M-1, where M = number of even samples = number of odd samples (1..128); latched at start.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- done  out  1  one-cycle pulse at end of pass.
- ev_addr, od_addr  out  AW  even/odd RAM addresses (synchronous read, 1-cycle latency).
- ev_we, od_we  out  1  RAM write enables.
- ev_din, od_din  out  W  RAM write data.
- ev_dout, od_dout  in  W  RAM read data.
- dp_left, dp_right, dp_center  out  W  registered operands to the datapath.
- dp_p  out  1  compute strobe; high in CALC and WR.
- dp_even_odd  out  1  1 = current step targets the odd RAM (predict), 0 = even RAM (update).
- dp_fwd_inv  out  1  latched fwd_inv_cfg.
- dp_result  in  W  combinational datapath result, valid while dp_p = 1.

Function
REQ-004 SHALL implement states IDLE, RL, RR, RC, CALC, WR, DONE; per element RL->RR->RC->CALC->WR, 5 cycles.
REQ-005 SHALL accept start only in IDLE; move to RL with phase = 0 and i = 0 and latch cfg/len_m1; start in any other state SHALL be ignored.
REQ-006 Phase order SHALL be: forward = predict then update; inverse = update then predict.
REQ-007 Predict element i SHALL use left = even[i], right = even[min(i+1, M-1)], center = odd[i], and write target odd[i].
REQ-008 Update element i SHALL use left = odd[max(i-1, 0)], right = odd[i], center = even[i], and write target even[i].
REQ-009 RL/RR/RC SHALL drive the address of left/right/center on the owning RAM; dp_left SHALL capture at end of RR, dp_right at end of RC, dp_center at end of CALC, each from the RAM that owns it.
REQ-010 WR SHALL drive the target address, target din = dp_result, and target we = 1 for exactly one cycle; the other we SHALL be 0.
REQ-011 A RAM not addressed in the current cycle SHALL have address 0 and we 0.
REQ-012 After WR: if i < M-1, SHALL go to i+1 and RL; else if phase 0, SHALL go to phase 1, i = 0, RL; else SHALL go to DONE.
REQ-013 DONE SHALL last one cycle with done = 1 and busy = 1, then go to IDLE with busy = 0.
REQ-014 Total busy cycles SHALL be 10*M+1 (M=1: 11; M=2: 21; M=128: 1281).
REQ-015 dp_even_odd SHALL be constant within a phase; dp_fwd_inv SHALL be constant for the whole pass.
REQ-016 Boundary clamps (REQ-007 right, REQ-008 left) SHALL also apply when M = 1, so that both operands read the same address.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, i = 0, phase = 0, and every output to 0, including any in-flight WR (we drops asynchronously).
REQ-018 After rst_n deasserts, the block SHALL wait in IDLE for a new start; an aborted pass SHALL NOT resume.

Verification
REQ-019 Reset: assert rst_n = 0 mid-idle and in random states -> all outputs 0 in the same cycle, state IDLE.
REQ-020 Forward, M = 2:
- predict addresses: ev 0, 1, od 0, write od 0; then ev 1, 1, od 1, write od 1.
- update addresses: od 0, 0, ev 0, write ev 0; then od 0, 1, ev 1, write ev 1.
- done on busy cycle 21.
REQ-021 Inverse, M = 1 -> update (od 0, 0, ev 0, write ev 0) then predict (ev 0, 0, od 0, write od 0); dp_fwd_inv = 0; done on busy cycle 11.
REQ-022 Datapath passthrough: dp_result = 0x12345 during predict WR -> od_din = 0x12345, od_we = 1 for one cycle, ev_we = 0.
REQ-023 Start pulses during busy and during DONE -> ignored, cycle count unchanged; start held high across DONE -> a new pass begins the cycle after IDLE is re-entered.
REQ-024 Reset asserted during WR of element 3, M = 8 -> no write, busy = 0; a subsequent start runs a full 81-cycle pass from i = 0.
